// File: rtl/phy_tx_multilane.sv
// Multilane PHY transmitter: round-robin channel arbitration, byte striping
// across lanes, MSB-first serialisation, COM training and IDLE fill.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_OFF    | link down, outputs quiet, bit counter held
// ST_SYNC   | training: every lane repeats COM_SYM
// ST_ACTIVE | data frames, lanes without a grant send IDLE
module phy_tx_multilane #(
    parameter int                DATA_W      = 8,
    parameter int                NUM_CH      = 2,
    parameter int                NUM_LANES   = 2,
    parameter logic [DATA_W-1:0] COM_SYM     = 8'hBC,
    parameter logic [DATA_W-1:0] IDLE_SYM    = 8'h7C,
    parameter int                SYNC_FRAMES = 4
) (
    input  logic                     clk_8f,
    input  logic                     reset_L,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        valid_in,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    output logic [NUM_CH-1:0]        ready_out,
    output logic [NUM_LANES-1:0]     tx_out,
    output logic [1:0]               link_state
);

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int SYNC_W = (SYNC_FRAMES > 1) ? $clog2(SYNC_FRAMES) : 1;

    localparam logic [1:0] ST_OFF    = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] sr_q [NUM_LANES];
    logic [DATA_W-1:0] sr_d [NUM_LANES];
    logic [NUM_LANES-1:0] tx_q, tx_d;

    logic              boundary;
    logic [NUM_CH-1:0] grant;
    logic [DATA_W-1:0] lane_sym [NUM_LANES];
    logic [CH_W-1:0]   last_ch;
    logic              any_grant;
    int                n_grant;
    int                scan_idx;

    assign boundary = (bit_cnt_q == BIT_W'(DATA_W - 1));

    // Grants exist only in the ACTIVE boundary cycle; the k-th grant in scan
    // order from rr_ptr feeds lane k.
    always_comb begin
        grant     = '0;
        last_ch   = rr_ptr_q;
        any_grant = 1'b0;
        n_grant   = 0;
        scan_idx  = 0;
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_sym[l] = IDLE_SYM;
        end
        if (state_q == ST_ACTIVE && enable && boundary) begin
            for (int i = 0; i < NUM_CH; i++) begin
                scan_idx = int'(rr_ptr_q) + i;
                if (scan_idx >= NUM_CH) begin
                    scan_idx = scan_idx - NUM_CH;
                end
                for (int c = 0; c < NUM_CH; c++) begin
                    if (c == scan_idx && valid_in[c] && n_grant < NUM_LANES) begin
                        grant[c] = 1'b1;
                        for (int l = 0; l < NUM_LANES; l++) begin
                            if (l == n_grant) begin
                                lane_sym[l] = data_in[c*DATA_W +: DATA_W];
                            end
                        end
                        last_ch   = CH_W'(c);
                        any_grant = 1'b1;
                        n_grant   = n_grant + 1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sync_cnt_d = sync_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        for (int l = 0; l < NUM_LANES; l++) begin
            sr_d[l] = sr_q[l] << 1;
            tx_d[l] = sr_q[l][DATA_W-1];
        end
        if (!enable) begin
            state_d    = ST_OFF;
            bit_cnt_d  = '0;
            sync_cnt_d = '0;
            tx_d       = '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                sr_d[l] = '0;
            end
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d    = ST_SYNC;
                    bit_cnt_d  = '0;
                    sync_cnt_d = '0;
                    tx_d       = '0;
                    for (int l = 0; l < NUM_LANES; l++) begin
                        sr_d[l] = COM_SYM;
                    end
                end
                ST_SYNC: begin
                    if (boundary) begin
                        bit_cnt_d = '0;
                        if (sync_cnt_q == SYNC_W'(SYNC_FRAMES - 1)) begin
                            state_d = ST_ACTIVE;
                            for (int l = 0; l < NUM_LANES; l++) begin
                                sr_d[l] = lane_sym[l];
                            end
                        end else begin
                            sync_cnt_d = sync_cnt_q + SYNC_W'(1);
                            for (int l = 0; l < NUM_LANES; l++) begin
                                sr_d[l] = COM_SYM;
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (boundary) begin
                        bit_cnt_d = '0;
                        for (int l = 0; l < NUM_LANES; l++) begin
                            sr_d[l] = lane_sym[l];
                        end
                        if (any_grant) begin
                            rr_ptr_d = (last_ch == CH_W'(NUM_CH - 1)) ? '0 : last_ch + CH_W'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
                default: begin
                    state_d   = ST_OFF;
                    bit_cnt_d = '0;
                    tx_d      = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= ST_OFF;
            bit_cnt_q  <= '0;
            sync_cnt_q <= '0;
            rr_ptr_q   <= '0;
            tx_q       <= '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                sr_q[l] <= '0;
            end
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sync_cnt_q <= sync_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_q       <= tx_d;
            for (int l = 0; l < NUM_LANES; l++) begin
                sr_q[l] <= sr_d[l];
            end
        end
    end

    assign ready_out  = grant;
    assign tx_out     = tx_q;
    assign link_state = state_q;

endmodule

// File: tb/tb_phy_tx_multilane.sv
// Scoreboard bench for phy_tx_multilane: expected lane bits are queued with
// the cycle they are due and compared as the serial stream comes out.
module tb_phy_tx_multilane;

    localparam int DW  = 8;
    localparam int NCH = 2;
    localparam int NL  = 2;
    localparam logic [DW-1:0] COM  = 8'hBC;
    localparam logic [DW-1:0] IDLE = 8'h7C;

    logic              clk_8f  = 1'b0;
    logic              reset_L = 1'b0;
    logic              enable  = 1'b0;
    logic [NCH-1:0]    valid_in = '0;
    logic [NCH*DW-1:0] data_in  = '0;
    logic [NCH-1:0]    ready_out;
    logic [NL-1:0]     tx_out;
    logic [1:0]        link_state;

    logic              enable3 = 1'b0;
    logic [2:0]        valid3  = '0;
    logic [3*DW-1:0]   data3   = '0;
    logic [2:0]        ready3;
    logic [1:0]        tx3;
    logic [1:0]        link3;

    phy_tx_multilane u_dut (
        .clk_8f(clk_8f), .reset_L(reset_L), .enable(enable),
        .valid_in(valid_in), .data_in(data_in), .ready_out(ready_out),
        .tx_out(tx_out), .link_state(link_state)
    );

    phy_tx_multilane #(.NUM_CH(3), .NUM_LANES(2)) u_dut3 (
        .clk_8f(clk_8f), .reset_L(reset_L), .enable(enable3),
        .valid_in(valid3), .data_in(data3), .ready_out(ready3),
        .tx_out(tx3), .link_state(link3)
    );

    always #5 clk_8f = ~clk_8f;

    int cyc = 0;
    always @(posedge clk_8f) cyc <= cyc + 1;

    typedef struct {
        int            due;
        logic [NL-1:0] bits;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   fails     = 0;
    int   rr_m      = 0;
    int   next_bnd  = 0;

    always @(negedge clk_8f) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            e = exp_q.pop_front();
            tests_run++;
            fails++;
            $display("FAIL lane_bits_missed: due cycle %0d never sampled (now %0d)", e.due, cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            tests_run++;
            if (tx_out !== e.bits) begin
                fails++;
                $display("FAIL lane_bits @cyc %0d: tx_out=%b expected %b", cyc, tx_out, e.bits);
            end
        end
    end

    task automatic goto_cyc(input int t);
        if (cyc > t) begin
            tests_run++;
            fails++;
            $display("FAIL schedule: now cycle %0d, wanted %0d", cyc, t);
        end
        while (cyc < t) @(negedge clk_8f);
    endtask

    // Queue one frame per lane, loaded at the edge that makes cyc == load_cyc.
    task automatic push_frame(input int load_cyc, input logic [NL*DW-1:0] syms);
        exp_t e;
        for (int k = 0; k < DW; k++) begin
            e.due = load_cyc + 1 + k;
            for (int l = 0; l < NL; l++) e.bits[l] = syms[l*DW + DW - 1 - k];
            exp_q.push_back(e);
        end
    endtask

    task automatic frame(input logic [NCH-1:0] v, input logic [NCH*DW-1:0] d);
        logic [NCH-1:0]   exp_rdy;
        logic [NL*DW-1:0] syms;
        int n, last, c;
        while (next_bnd < cyc) next_bnd += DW;
        goto_cyc(next_bnd);
        valid_in = v;
        data_in  = d;
        #1;
        exp_rdy = '0;
        n       = 0;
        last    = rr_m;
        for (int l = 0; l < NL; l++) syms[l*DW +: DW] = IDLE;
        for (int i = 0; i < NCH; i++) begin
            c = (rr_m + i) % NCH;
            if (v[c] && n < NL) begin
                exp_rdy[c]       = 1'b1;
                syms[n*DW +: DW] = d[c*DW +: DW];
                n++;
                last = c;
            end
        end
        if (n > 0) rr_m = (last + 1) % NCH;
        tests_run++;
        if (ready_out !== exp_rdy) begin
            fails++;
            $display("FAIL frame_grant @cyc %0d: ready_out=%b expected %b", cyc, ready_out, exp_rdy);
        end
        push_frame(cyc + 1, syms);
        next_bnd += DW;
        @(negedge clk_8f);
        valid_in = '0;
    endtask

    task automatic do_training(input bit rel_rst);
        logic [NL*DW-1:0] com_s, idle_s;
        logic [1:0]       exp_ls;
        int e0;
        for (int l = 0; l < NL; l++) begin
            com_s[l*DW +: DW]  = COM;
            idle_s[l*DW +: DW] = IDLE;
        end
        tests_run++;
        if (link_state !== 2'd0) begin
            fails++;
            $display("FAIL train_off: link_state=%0d expected 0", link_state);
        end
        if (rel_rst) reset_L = 1'b1;
        enable = 1'b1;
        e0 = cyc + 1;
        for (int f = 0; f < 4; f++) push_frame(e0 + 8*f, com_s);
        push_frame(e0 + 32, idle_s);
        while (cyc < e0 + 38) begin
            @(negedge clk_8f);
            exp_ls = (cyc < e0 + 32) ? 2'd1 : 2'd2;
            tests_run++;
            if (link_state !== exp_ls) begin
                fails++;
                $display("FAIL train_state @cyc %0d: link_state=%0d expected %0d", cyc, link_state, exp_ls);
            end
            tests_run++;
            if (ready_out !== '0) begin
                fails++;
                $display("FAIL train_ready @cyc %0d: ready_out=%b expected 00", cyc, ready_out);
            end
        end
        next_bnd = e0 + 39;
    endtask

    task automatic test_reset();
        reset_L  = 1'b0;
        enable   = 1'b1;
        valid_in = 2'b11;
        data_in  = 16'hFFFF;
        repeat (3) @(negedge clk_8f);
        tests_run++;
        if (tx_out !== 2'b00) begin
            fails++;
            $display("FAIL reset_tx: tx_out=%b expected 00", tx_out);
        end
        tests_run++;
        if (link_state !== 2'd0) begin
            fails++;
            $display("FAIL reset_state: link_state=%0d expected 0", link_state);
        end
        tests_run++;
        if (ready_out !== 2'b00) begin
            fails++;
            $display("FAIL reset_ready: ready_out=%b expected 00", ready_out);
        end
        valid_in = '0;
    endtask

    task automatic test_training();
        do_training(1'b1);
    endtask

    task automatic test_full_load();
        frame(2'b11, {8'h3C, 8'hA5});
    endtask

    task automatic test_partial_idle();
        frame(2'b01, {8'h00, 8'h12});
        frame(2'b10, {8'hFF, 8'h00});
        frame(2'b00, {8'h99, 8'h99});
        frame(2'b11, {8'hAA, 8'h55});
    endtask

    task automatic test_handshake();
        int b;
        while (next_bnd < cyc) next_bnd += DW;
        b = next_bnd;
        goto_cyc(b - 5);
        valid_in = 2'b11;
        data_in  = {8'hC3, 8'h96};
        #1;
        tests_run++;
        if (ready_out !== 2'b00) begin
            fails++;
            $display("FAIL hs_midframe: ready_out=%b expected 00", ready_out);
        end
        @(negedge clk_8f);
        goto_cyc(b - 2);
        tests_run++;
        if (ready_out !== 2'b00) begin
            fails++;
            $display("FAIL hs_preboundary: ready_out=%b expected 00", ready_out);
        end
        goto_cyc(b - 1);
        valid_in = 2'b01;
        frame(2'b01, {8'hC3, 8'h96});
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_r;
        logic [1:0] exp_b;
        int e0;
        enable3 = 1'b1;
        valid3  = 3'b111;
        data3   = {8'h33, 8'h22, 8'h11};
        e0 = cyc + 1;
        goto_cyc(e0 + 31);
        tests_run++;
        if (ready3 !== 3'b000) begin
            fails++;
            $display("FAIL rr_sync: ready=%b expected 000", ready3);
        end
        goto_cyc(e0 + 39);
        tests_run++;
        if (ready3 !== 3'b011) begin
            fails++;
            $display("FAIL rr_frame1: ready=%b expected 011", ready3);
        end
        goto_cyc(e0 + 40);
        tests_run++;
        if (ready3 !== 3'b000) begin
            fails++;
            $display("FAIL rr_nonboundary: ready=%b expected 000", ready3);
        end
        goto_cyc(e0 + 47);
        tests_run++;
        if (ready3 !== 3'b101) begin
            fails++;
            $display("FAIL rr_frame2: ready=%b expected 101", ready3);
        end
        for (int k = 0; k < DW; k++) begin
            goto_cyc(e0 + 49 + k);
            exp_b = {data3[DW - 1 - k], data3[2*DW + DW - 1 - k]};
            tests_run++;
            if (tx3 !== exp_b) begin
                fails++;
                $display("FAIL rr_lane_map bit %0d: tx=%b expected %b", k, tx3, exp_b);
            end
            if (k == 6) begin
                exp_r = 3'b110;
                tests_run++;
                if (ready3 !== exp_r) begin
                    fails++;
                    $display("FAIL rr_frame3: ready=%b expected %b", ready3, exp_r);
                end
            end
        end
        enable3 = 1'b0;
        valid3  = '0;
    endtask

    task automatic test_abort();
        int b;
        frame(2'b11, {8'hFF, 8'hFF});
        b = next_bnd - DW;
        goto_cyc(b + 4);
        tests_run++;
        if (tx_out !== 2'b11) begin
            fails++;
            $display("FAIL abort_before: tx_out=%b expected 11", tx_out);
        end
        enable = 1'b0;
        exp_q.delete();
        @(negedge clk_8f);
        tests_run++;
        if (tx_out !== 2'b00 || link_state !== 2'd0) begin
            fails++;
            $display("FAIL abort_off: tx_out=%b link_state=%0d expected 00/0", tx_out, link_state);
        end
        repeat (3) @(negedge clk_8f);
        tests_run++;
        if (tx_out !== 2'b00 || link_state !== 2'd0) begin
            fails++;
            $display("FAIL abort_hold: tx_out=%b link_state=%0d expected 00/0", tx_out, link_state);
        end
        valid_in = 2'b11;
        data_in  = {8'hF0, 8'h0F};
        do_training(1'b0);
        frame(2'b11, {8'hF0, 8'h0F});

        frame(2'b11, {8'hFF, 8'hFF});
        b = next_bnd - DW;
        goto_cyc(b + 3);
        tests_run++;
        if (tx_out !== 2'b11) begin
            fails++;
            $display("FAIL areset_before: tx_out=%b expected 11", tx_out);
        end
        valid_in = 2'b11;
        #2;
        reset_L = 1'b0;
        exp_q.delete();
        rr_m = 0;
        #1;
        tests_run++;
        if (tx_out !== 2'b00 || link_state !== 2'd0 || ready_out !== 2'b00) begin
            fails++;
            $display("FAIL areset_async: tx_out=%b link_state=%0d ready_out=%b expected 00/0/00",
                     tx_out, link_state, ready_out);
        end
        @(negedge clk_8f);
        enable   = 1'b0;
        valid_in = '0;
        reset_L  = 1'b1;
        repeat (2) @(negedge clk_8f);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk_8f);
        test_reset();
        test_training();
        test_full_load();
        test_partial_idle();
        test_handshake();
        test_round_robin();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/phy_tx_multilane.md
Name: phy_tx_multilane

Overview:
Parametrised next-generation PHY transmitter. It takes NUM_CH parallel byte channels with a valid/ready handshake and arbitrates them round-robin. Accepted bytes are striped across NUM_LANES serial lanes, and every lane is serialised MSB-first on the single bit clock. Derived clocks are replaced by an internal frame counter. The block adds a link-training (sync) phase and an idle-symbol fill that the two-lane fixed transmitter lacks.

Parameters:
DATA_W, 8, symbol/byte width; a frame is DATA_W bit-clock cycles.
NUM_CH, 2, input channels (>=1).
NUM_LANES, 2, serial output lanes (>=1, any relation to NUM_CH).
COM_SYM, 8'hBC, training symbol (DATA_W bits).
IDLE_SYM, 8'h7C, filler symbol for lanes with no data in a frame.
SYNC_FRAMES, 4, number of COM frames sent before the block goes ACTIVE (>=1).

Ports:
clk_8f  in  1  bit clock, the only clock.
reset_L  in  1  asynchronous active-low reset.
enable  in  1  link enable.
valid_in  in  NUM_CH  per-channel byte valid.
data_in  in  NUM_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W].
ready_out  out  NUM_CH  per-channel grant (combinational).
tx_out  out  NUM_LANES  registered serial lane outputs.
link_state  out  2  0=OFF, 1=SYNC, 2=ACTIVE.

Behaviour:
- Reset is asynchronous and active-low. On reset: tx_out=0, link_state=OFF, bit_cnt=0, rr_ptr=0, sync_cnt=0, all shift registers=0. ready_out=0 while reset_L=0.
- bit_cnt counts 0..DATA_W-1 and wraps while enable=1. The boundary cycle is bit_cnt==DATA_W-1.
- OFF:
  - bit_cnt is held at 0, tx_out=0, ready_out=0.
  - enable=1 moves to SYNC on the next edge, with sync_cnt=0 and every shift register loaded with COM_SYM.
- SYNC:
  - Every lane serialises COM_SYM.
  - At each boundary, sync_cnt increments and all lanes reload COM_SYM.
  - At the boundary where sync_cnt==SYNC_FRAMES-1, the block goes to ACTIVE and that same edge performs the first ACTIVE load.
  - ready_out=0 throughout SYNC.
- ACTIVE: ready_out is nonzero only in the boundary cycle.
  - Scan starts at rr_ptr and walks the channels in cyclic order.
  - The first min(NUM_LANES, number of valid channels) valid channels are granted, at most one byte per channel per frame.
  - The k-th granted byte in scan order goes to lane k.
  - Lanes k >= number of grants load IDLE_SYM.
  - rr_ptr becomes (last granted channel + 1) mod NUM_CH. It is unchanged if nothing was granted.
  - A transfer happens only when valid_in[c]=1 and ready_out[c]=1 in the same cycle.
- Serialisation:
  - Shift registers load at the boundary edge and then shift left one bit per cycle.
  - tx_out[l] is registered from the shift register MSB.
  - For a load at edge E, bit DATA_W-1 is on tx_out after edge E+1, and bit 0 after edge E+DATA_W.
  - The next frame is contiguous, with no gap bits.
- enable deassertion:
  - enable=0 in any state moves to OFF at the next edge. tx_out is cleared and bit_cnt is reset at the same time.
  - A partially sent frame is abandoned.
  - Re-enabling always restarts the SYNC phase.
- An asynchronous reset mid-frame returns every register to its reset value immediately.
- Simultaneous enable rise and reset release: reset dominates; SYNC starts at the first edge with reset_L=1 and enable=1.
- Data is never buffered beyond the shift registers. A channel that is not granted must hold its valid_in and data_in.

Test Plan:
1. Training phase: defaults; release reset; enable=1; no valid inputs -> both lanes output bit pattern 10111100 repeated 4 times (32 cycles); link_state 1 then 2; afterwards 01111100 on both lanes.
2. Full load: both channels valid with 8'hA5 and 8'h3C at an ACTIVE boundary -> ready_out=2'b11; lane0 10100101, lane1 00111100; first bit appears one edge after the load.
3. Round-robin: NUM_CH=3, NUM_LANES=2, all channels always valid -> grants {0,1}, {2,0}, {1,2} in successive frames.
4. Partial and idle fill: only ch1 valid with 8'hFF -> lane0 carries 8'hFF, lane1 carries IDLE_SYM; rr_ptr goes to 0.
5. Handshake timing: valid_in asserted mid-frame -> ready_out stays 0 until the boundary cycle; valid dropped before the boundary -> no transfer; lane sends IDLE.
6. Abort: enable deasserted at bit 3 of an ACTIVE frame -> tx_out=0 next edge, link_state=0; re-enable -> full 4-frame COM sequence before any grant. Async reset pulse mid-frame -> outputs 0 without a clock edge.
